// File: rtl/input_sampler.sv
// input_sampler: frame-synchronous capture of player inputs with sticky press flags,
// spinner accumulation and a 16-bit CPU register port.
// Optional: define INPUT_SAMPLER_PRESSCNT_EN to build per-port press counters at offset +7.
module input_sampler #(
    parameter int NUM_PORTS = 6,
    parameter int BTN_W     = 32,
    parameter int SPIN_SAT  = 1,
    localparam int AW       = $clog2(NUM_PORTS*8+1)
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       vblank,
    input  logic [NUM_PORTS*BTN_W-1:0] joystick,
    input  logic [NUM_PORTS*16-1:0]    analog,
    input  logic [NUM_PORTS*8-1:0]     paddle,
    input  logic [NUM_PORTS*9-1:0]     spinner,
    input  logic [AW-1:0]              cpu_addr,
    input  logic                       cpu_rd,
    input  logic                       cpu_wr,
    output logic [15:0]                cpu_dout,
    output logic                       cpu_dout_valid,
    output logic                       frame_strobe
);
    logic                  vb_d;
    logic                  rise;
    logic                  frame_sel;
    logic [15:0]           frame_cnt;
    logic [15:0]           rdata;
    logic [NUM_PORTS-1:0]  sel;
    logic [NUM_PORTS-1:0]  sp_d;
    logic [NUM_PORTS-1:0]  tog;
    logic [31:0]           btn_in    [NUM_PORTS];
    logic [31:0]           cur_btn   [NUM_PORTS];
    logic [31:0]           press     [NUM_PORTS];
    logic [31:0]           new_press [NUM_PORTS];
    logic [31:0]           clr       [NUM_PORTS];
    logic [15:0]           analog_q  [NUM_PORTS];
    logic [7:0]            paddle_q  [NUM_PORTS];
    logic [15:0]           spin_acc  [NUM_PORTS];
    logic [15:0]           spin_nxt  [NUM_PORTS];
    logic [15:0]           spin_sext [NUM_PORTS];
    logic signed [16:0]    spin_sum  [NUM_PORTS];
    logic [15:0]           press_cnt [NUM_PORTS];

    assign rise      = vblank & ~vb_d;
    assign frame_sel = cpu_addr == AW'(NUM_PORTS*8);

    // Per-port decode, edge detection and spinner next-value with optional clamp
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel[p]       = cpu_addr[AW-1:3] == (AW-3)'(p);
            btn_in[p]    = 32'(joystick[p*BTN_W +: BTN_W]);
            new_press[p] = btn_in[p] & ~cur_btn[p];
            clr[p]       = {{16{cpu_rd && sel[p] && cpu_addr[2:0] == 3'd3}},
                            {16{cpu_rd && sel[p] && cpu_addr[2:0] == 3'd2}}};
            tog[p]       = spinner[p*9+8] ^ sp_d[p];
            spin_sext[p] = {{8{spinner[p*9+7]}}, spinner[p*9 +: 8]};
            spin_sum[p]  = {spin_acc[p][15], spin_acc[p]} + {spin_sext[p][15], spin_sext[p]};
            spin_nxt[p]  = (SPIN_SAT != 0 && spin_sum[p] > 17'sd32767)  ? 16'h7FFF :
                           (SPIN_SAT != 0 && spin_sum[p] < -17'sd32767) ? 16'h8001 :
                           spin_sum[p][15:0];
        end
    end

    // Register read multiplexer; unmapped addresses return zero
    always_comb begin
        rdata = 16'h0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel[p]) begin
                case (cpu_addr[2:0])
                    3'd0: rdata = cur_btn[p][15:0];
                    3'd1: rdata = cur_btn[p][31:16];
                    3'd2: rdata = press[p][15:0];
                    3'd3: rdata = press[p][31:16];
                    3'd4: rdata = analog_q[p];
                    3'd5: rdata = {8'h0, paddle_q[p]};
                    3'd6: rdata = spin_acc[p];
                    3'd7: rdata = press_cnt[p];
                endcase
            end
        end
        if (frame_sel) rdata = frame_cnt;
    end

    // Frame detect, snapshots, sticky press flags, spinner accumulation and CPU read port
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vb_d           <= 1'b1;
            frame_strobe   <= 1'b0;
            frame_cnt      <= 16'h0;
            cpu_dout       <= 16'h0;
            cpu_dout_valid <= 1'b0;
            sp_d           <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cur_btn[p]  <= '0;
                press[p]    <= '0;
                analog_q[p] <= '0;
                paddle_q[p] <= '0;
                spin_acc[p] <= '0;
            end
        end else begin
            vb_d           <= vblank;
            frame_strobe   <= rise;
            frame_cnt      <= (cpu_wr && frame_sel) ? {15'h0, rise} : frame_cnt + {15'h0, rise};
            cpu_dout_valid <= cpu_rd;
            if (cpu_rd) cpu_dout <= rdata;
            for (int p = 0; p < NUM_PORTS; p++) begin
                sp_d[p]  <= spinner[p*9+8];
                press[p] <= (press[p] & ~clr[p]) | (rise ? new_press[p] : 32'h0);
                if (rise) begin
                    cur_btn[p]  <= btn_in[p];
                    analog_q[p] <= analog[p*16 +: 16];
                    paddle_q[p] <= paddle[p*8 +: 8];
                end
                if (cpu_wr && sel[p] && cpu_addr[2:0] == 3'd6)
                    spin_acc[p] <= tog[p] ? spin_sext[p] : 16'h0;
                else if (tog[p])
                    spin_acc[p] <= spin_nxt[p];
            end
        end
    end

`ifdef INPUT_SAMPLER_PRESSCNT_EN
    // Saturating count of snapshots that brought at least one new press
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) press_cnt[p] <= 16'h0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cpu_wr && sel[p] && cpu_addr[2:0] == 3'd7)
                    press_cnt[p] <= {15'h0, rise && |new_press[p]};
                else if (rise && |new_press[p] && press_cnt[p] != 16'hFFFF)
                    press_cnt[p] <= press_cnt[p] + 16'h1;
            end
        end
    end
`else
    // Counters not built: offset +7 reads zero
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) press_cnt[p] = 16'h0;
    end
`endif
endmodule
